mc_pi_multilane: RTL and testbench
==================================

Name: mc_pi_multilane

Overview:
- Multi-lane Monte Carlo pi estimator; parametrised successor of the single-lane estimator.
- LANES independent LFSR generators each produce one (x,y) point per cycle. Each point is classified inside or outside the quarter circle of radius 2^COORD_W, through a 3-stage pipeline.
- Accumulates hit and miss counts until points_num samples are done, then raises finish.
- Sits under the top-level host/UART control as the compute core.

Parameters:
- LANES, 4, number of parallel sample lanes (1..16).
- COORD_W, 8, coordinate width in bits; legal values 4, 8, 16. LFSR width is 2*COORD_W.
- CNT_W, 32, width of points_num and all counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a run. Accepted only in IDLE or DONE.
- points_num  in  CNT_W  sample count for the run; latched on an accepted start.
- seed  in  32  base seed; latched on an accepted start.
- busy  out  1  high in RUN and DRAIN.
- finish  out  1  high in DONE; held until the next accepted start or reset.
- pi_yes  out  CNT_W  count of samples inside the circle.
- pi_no  out  CNT_W  count of samples outside the circle.
- rng_exhaust  out  1  sticky; any lane's LFSR has returned to its seeded state.

Behaviour:
- Reset (asynchronous, any state including mid-run):
  - state = IDLE.
  - busy = 0, finish = 0, pi_yes = 0, pi_no = 0, rng_exhaust = 0.
  - Pipeline valids cleared; LFSR state = 1.
- States:
  - IDLE: start -> RUN.
  - RUN: last issue cycle -> DRAIN.
  - DRAIN: pipeline empty -> DONE.
  - DONE: start -> RUN.
  - points_num = 0: start goes straight to DONE; finish rises the next cycle with counts 0.
- Accepted start:
  - Clears pi_yes, pi_no, rng_exhaust.
  - Latches points_num into remaining.
  - Seeds lane i with s_i = (seed + i*32'h9E3779B9) truncated to 2*COORD_W bits; if s_i == 0, uses 1.
  - start while busy is ignored, with no state change.
- LFSR: Fibonacci, shift left, feedback bit = XOR of tap bits, advances every RUN cycle.
  - 8-bit taps: 8,6,5,4.
  - 16-bit taps: 16,14,13,11.
  - 32-bit taps: 32,22,2,1.
  - Point x = state[2W-1:W], y = state[W-1:0], sampled before the advance.
- Issue: each RUN cycle issues k = min(LANES, remaining) samples.
  - Lanes 0..k-1 are valid; lanes k.. are masked.
  - remaining decrements by k; RUN exits when remaining reaches 0.
  - All lanes advance regardless of mask.
- Pipeline, with a valid bit per lane:
  - S1: x^2 and y^2, each 2W bits.
  - S2: r2 = x^2 + y^2, 2W+1 bits.
  - S3: inside = (r2 < 2^(2W)), strictly less.
  - Accumulate: pi_yes += popcount(valid & inside); pi_no += popcount(valid & ~inside).
- Latency: counter update occurs 3 cycles after issue.
- Finish timing: finish rises exactly ceil(N/LANES)+4 cycles after the clock edge that samples start.
- Invariant in DONE: pi_yes + pi_no == latched points_num.
- Counters wrap modulo 2^CNT_W; no saturation.
- rng_exhaust sets when any lane's post-advance state equals its s_i.
  - Stays set until the next accepted start or reset.
  - Does not stop the run.
- A points_num change after start has no effect on the current run.

Test Plan:
- Reset mid-RUN: LANES=4, COORD_W=8, N=1000, assert rst at cycle 50 -> all outputs 0 within the same cycle; IDLE; a subsequent start runs cleanly.
- Count/timing: LANES=4, N=10 -> busy for cycles 1..6; finish rises at cycle 7 after the start edge; pi_yes + pi_no == 10; per-lane counts match a bit-exact reference model.
- Exhaust: COORD_W=4, LANES=1, N=300 -> rng_exhaust rises after the 255th advance and stays high; finish still rises; pi_yes + pi_no == 300.
- Boundary: COORD_W=4, seed forcing lane 0 state 8'hFF (x=15, y=15, r2=450) counts as no; state 8'h0F (x=0, y=15, r2=225) counts as yes.
- Zero/ignored start: N=0 -> finish the next cycle with counts 0. start pulsed during RUN of N=100 -> ignored; final sum == 100.
- Restart from DONE: second start with N=8, LANES=4 -> counters cleared; finish low during the run and high 6 cycles after start; sum == 8.

Source files
------------

// File: rtl/mc_pi_multilane.sv
// Multi-lane Monte Carlo pi estimator core.
// LANES LFSRs each produce one (x,y) point per RUN cycle. A 3-stage pipeline
// classifies each point against the quarter circle of radius 2^COORD_W, and
// hit/miss counters accumulate until points_num samples have been classified.
module mc_pi_multilane #(
    parameter int LANES   = 4,
    parameter int COORD_W = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] points_num,
    input  logic [31:0]      seed,
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] pi_yes,
    output logic [CNT_W-1:0] pi_no,
    output logic             rng_exhaust
);

    localparam int LW = 2 * COORD_W;
    // Fibonacci tap positions (0-based) for the 8/16/32-bit LFSR widths
    localparam int T1 = (LW == 8) ? 7 : (LW == 16) ? 15 : 31;
    localparam int T2 = (LW == 8) ? 5 : (LW == 16) ? 13 : 21;
    localparam int T3 = (LW == 8) ? 4 : (LW == 16) ? 12 : 1;
    localparam int T4 = (LW == 8) ? 3 : (LW == 16) ? 10 : 0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [LW-1:0] lfsr_next(input logic [LW-1:0] s);
        return {s[LW-2:0], s[T1] ^ s[T2] ^ s[T3] ^ s[T4]};
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    state_t           state, state_next;
    logic [CNT_W-1:0] remaining;
    logic [LW-1:0]    lfsr      [LANES];
    logic [LW-1:0]    lane_seed [LANES];
    logic [LW-1:0]    seed_init [LANES];
    logic [LW-1:0]    lfsr_adv  [LANES];
    logic [LANES-1:0] exhaust_hit;
    logic [LANES-1:0] issue_mask;
    logic [CNT_W-1:0] issue_k;
    logic             accept;
    logic             last_issue;
    logic             pipe_empty;

    logic [LANES-1:0] s1_valid, s2_valid, s3_valid, s3_inside;
    logic [LW-1:0]    s1_xx [LANES];
    logic [LW-1:0]    s1_yy [LANES];
    logic [LW:0]      s2_r2 [LANES];

    // Per-lane seeds, advanced LFSR values, exhaust detection and issue mask
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            seed_init[i] = LW'(seed + 32'(i) * 32'h9E3779B9);
            if (seed_init[i] == {LW{1'b0}}) begin
                seed_init[i] = LW'(1);
            end else begin
                seed_init[i] = seed_init[i];
            end
            lfsr_adv[i]    = lfsr_next(lfsr[i]);
            exhaust_hit[i] = (lfsr_adv[i] == lane_seed[i]);
            issue_mask[i]  = (CNT_W'(i) < remaining);
        end
    end

    assign issue_k    = (remaining < CNT_W'(LANES)) ? remaining : CNT_W'(LANES);
    assign last_issue = (remaining <= CNT_W'(LANES));
    assign pipe_empty = ~(|{s1_valid, s2_valid, s3_valid});
    assign accept     = start && ((state == IDLE) || (state == DONE));

    // Next-state logic for the run controller
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = (points_num == {CNT_W{1'b0}}) ? DONE : RUN;
                end else begin
                    state_next = state;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_next = DRAIN;
                end else begin
                    state_next = RUN;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_next = DONE;
                end else begin
                    state_next = DRAIN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, status flags, LFSRs, issue bookkeeping and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            finish      <= 1'b0;
            remaining   <= {CNT_W{1'b0}};
            pi_yes      <= {CNT_W{1'b0}};
            pi_no       <= {CNT_W{1'b0}};
            rng_exhaust <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lfsr[i]      <= LW'(1);
                lane_seed[i] <= LW'(1);
            end
        end else begin
            state  <= state_next;
            busy   <= (state_next == RUN) || (state_next == DRAIN);
            finish <= (state_next == DONE);
            if (accept) begin
                remaining   <= points_num;
                pi_yes      <= {CNT_W{1'b0}};
                pi_no       <= {CNT_W{1'b0}};
                rng_exhaust <= 1'b0;
                for (int i = 0; i < LANES; i++) begin
                    lfsr[i]      <= seed_init[i];
                    lane_seed[i] <= seed_init[i];
                end
            end else begin
                if (state == RUN) begin
                    remaining <= remaining - issue_k;
                    for (int i = 0; i < LANES; i++) begin
                        lfsr[i] <= lfsr_adv[i];
                    end
                    rng_exhaust <= rng_exhaust | (|exhaust_hit);
                end else begin
                    remaining <= remaining;
                end
                pi_yes <= pi_yes + popcount(s3_valid & s3_inside);
                pi_no  <= pi_no + popcount(s3_valid & ~s3_inside);
            end
        end
    end

    // Classification pipeline: square, sum, compare against 2^(2W)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= {LANES{1'b0}};
            s2_valid  <= {LANES{1'b0}};
            s3_valid  <= {LANES{1'b0}};
            s3_inside <= {LANES{1'b0}};
            for (int i = 0; i < LANES; i++) begin
                s1_xx[i] <= {LW{1'b0}};
                s1_yy[i] <= {LW{1'b0}};
                s2_r2[i] <= {(LW+1){1'b0}};
            end
        end else begin
            s1_valid <= (state == RUN) ? issue_mask : {LANES{1'b0}};
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            for (int i = 0; i < LANES; i++) begin
                s1_xx[i]     <= LW'(lfsr[i][LW-1:COORD_W]) * LW'(lfsr[i][LW-1:COORD_W]);
                s1_yy[i]     <= LW'(lfsr[i][COORD_W-1:0]) * LW'(lfsr[i][COORD_W-1:0]);
                s2_r2[i]     <= {1'b0, s1_xx[i]} + {1'b0, s1_yy[i]};
                // r2 < 2^(2W) exactly when the carry bit of the sum is clear
                s3_inside[i] <= ~s2_r2[i][LW];
            end
        end
    end

endmodule

// File: tb/tb_mc_pi_multilane.sv
// Self-checking bench for mc_pi_multilane: a 4-lane/8-bit instance (a) and a
// 1-lane/4-bit instance (b) share clock and reset.
module tb_mc_pi_multilane;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [31:0] n_a, n_b, seed_a, seed_b;
    logic        busy_a, busy_b, finish_a, finish_b, exh_a, exh_b;
    logic [31:0] yes_a, no_a, yes_b, no_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_pi_multilane #(.LANES(4), .COORD_W(8), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .points_num(n_a), .seed(seed_a),
        .busy(busy_a), .finish(finish_a), .pi_yes(yes_a), .pi_no(no_a),
        .rng_exhaust(exh_a)
    );

    mc_pi_multilane #(.LANES(1), .COORD_W(4), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .points_num(n_b), .seed(seed_b),
        .busy(busy_b), .finish(finish_b), .pi_yes(yes_b), .pi_no(no_b),
        .rng_exhaust(exh_b)
    );

    typedef struct {
        logic [31:0] seed;
        int          n;
        int          exp_yes;
        int          exp_no;
        int          exp_cyc;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Independent reference: count inside/outside for a run
    function automatic void model(input int cw, input int lanes, input logic [31:0] seed,
                                  input int n, output int yes, output int no);
        logic [31:0] st [16];
        logic [31:0] mask, cmask;
        logic        fb;
        int          lw, rem, k;
        longint      x, y, r2;
        lw    = 2 * cw;
        mask  = (lw == 32) ? 32'hFFFF_FFFF : ((32'd1 << lw) - 32'd1);
        cmask = (32'd1 << cw) - 32'd1;
        for (int i = 0; i < lanes; i++) begin
            st[i] = (seed + 32'(i) * 32'h9E3779B9) & mask;
            if (st[i] == 32'd0) st[i] = 32'd1;
        end
        yes = 0;
        no  = 0;
        rem = n;
        while (rem > 0) begin
            k = (rem < lanes) ? rem : lanes;
            for (int i = 0; i < lanes; i++) begin
                if (i < k) begin
                    x  = longint'((st[i] >> cw) & cmask);
                    y  = longint'(st[i] & cmask);
                    r2 = x * x + y * y;
                    if (r2 < (longint'(1) << lw)) yes++;
                    else no++;
                end
                case (lw)
                    8:  fb = st[i][7] ^ st[i][5] ^ st[i][4] ^ st[i][3];
                    16: fb = st[i][15] ^ st[i][13] ^ st[i][12] ^ st[i][10];
                    default: fb = st[i][31] ^ st[i][21] ^ st[i][1] ^ st[i][0];
                endcase
                st[i] = ((st[i] << 1) | 32'(fb)) & mask;
            end
            rem -= k;
        end
    endfunction

    // Start a run on instance a; optionally pulse start again at cycle poke
    task automatic run_a(input logic [31:0] s, input int n, input int poke,
                         output int cyc, output bit busy_ok, output bit run0);
        seed_a  = s;
        n_a     = n;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        run0    = busy_a && !finish_a;
        busy_ok = 1'b1;
        cyc     = 0;
        while (!finish_a && cyc < 3000) begin
            if (cyc == poke) begin
                start_a = 1'b1;
                n_a     = 7;
                seed_a  = ~s;
            end
            @(posedge clk); #1;
            start_a = 1'b0;
            cyc++;
            if (!finish_a && !busy_a) busy_ok = 1'b0;
        end
    endtask

    // Start a run on instance b
    task automatic run_b(input logic [31:0] s, input int n, output int cyc, output bit run0);
        seed_b  = s;
        n_b     = n;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        run0    = busy_b && !finish_b;
        cyc     = 0;
        while (!finish_b && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int  cyc, my, mn;
        bit  busy_ok, run0;

        // seed, n, yes, no, cycles-to-finish   (LANES=1, COORD_W=4)
        tbl[0] = '{32'h0000_0000, 0, 0, 0, 0};   // zero-length run
        tbl[1] = '{32'h0000_00FF, 1, 0, 1, 5};   // (15,15) r2=450
        tbl[2] = '{32'h0000_000F, 1, 1, 0, 5};   // (0,15) r2=225
        tbl[3] = '{32'hABCD_12FF, 1, 0, 1, 5};   // upper seed bits dropped
        tbl[4] = '{32'h0000_0000, 1, 1, 0, 5};   // zero seed -> 1 -> (0,1)
        tbl[5] = '{32'h0000_00BC, 1, 0, 1, 5};   // (11,12) r2=265
        tbl[6] = '{32'h0000_009C, 1, 1, 0, 5};   // (9,12) r2=225
        tbl[7] = '{32'h0000_00FF, 2, 0, 2, 6};   // FF then FE (15,14) r2=421
        tbl[8] = '{32'h0000_000F, 2, 2, 0, 6};   // 0F then 1F (1,15) r2=226

        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        n_a = 32'd0; n_b = 32'd0; seed_a = 32'd0; seed_b = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_a", {busy_a, finish_a, exh_a, yes_a, no_a}, 0);
        check("reset_b", {busy_b, finish_b, exh_b, yes_b, no_b}, 0);

        for (int v = 0; v < 9; v++) begin
            run_b(tbl[v].seed, tbl[v].n, cyc, run0);
            if (tbl[v].n > 0) check($sformatf("v%0d_running", v), run0, 1);
            check($sformatf("v%0d_cycles", v), cyc, tbl[v].exp_cyc);
            check($sformatf("v%0d_yes", v), yes_b, tbl[v].exp_yes);
            check($sformatf("v%0d_no", v), no_b, tbl[v].exp_no);
            check($sformatf("v%0d_busy_done", v), busy_b, 0);
        end

        // LFSR exhaustion on the 8-bit generator: period 255
        seed_b = 32'h0000_005A; n_b = 300; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cyc = 0;
        while (!finish_b && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 254) check("exh_before_255", exh_b, 0);
            if (cyc == 255) check("exh_at_255", exh_b, 1);
        end
        model(4, 1, 32'h0000_005A, 300, my, mn);
        check("exh_cycles", cyc, 304);
        check("exh_sticky", exh_b, 1);
        check("exh_sum", yes_b + no_b, 300);
        check("exh_yes", yes_b, my);

        // Asynchronous reset in the middle of a long run
        seed_a = 32'hDEAD_BEEF; n_a = 1000; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", busy_a, 1);
        rst = 1'b1;
        #1;
        check("midrun_reset", {busy_a, finish_a, exh_a, yes_a, no_a}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", {busy_a, finish_a}, 0);

        // Count/timing: N=10 on 4 lanes
        run_a(32'h1234_5678, 10, -1, cyc, busy_ok, run0);
        model(8, 4, 32'h1234_5678, 10, my, mn);
        check("n10_running", run0, 1);
        check("n10_busy_held", busy_ok, 1);
        check("n10_cycles", cyc, 7);
        check("n10_busy_done", busy_a, 0);
        check("n10_yes", yes_a, my);
        check("n10_no", no_a, mn);

        // start during RUN is ignored, including the new points_num/seed
        run_a(32'hCAFE_0123, 100, 5, cyc, busy_ok, run0);
        model(8, 4, 32'hCAFE_0123, 100, my, mn);
        check("ign_cycles", cyc, 29);
        check("ign_sum", yes_a + no_a, 100);
        check("ign_yes", yes_a, my);

        // Restart from DONE
        run_a(32'h0BAD_F00D, 8, -1, cyc, busy_ok, run0);
        model(8, 4, 32'h0BAD_F00D, 8, my, mn);
        check("re_finish_low", run0, 1);
        check("re_cycles", cyc, 6);
        check("re_yes", yes_a, my);
        check("re_no", no_a, mn);

        // Zero-length run on the 4-lane instance from DONE
        run_a(32'h0000_0001, 0, -1, cyc, busy_ok, run0);
        check("zero_a_cycles", cyc, 0);
        check("zero_a_counts", {yes_a, no_a}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
